// File: rtl/hashcore_seq_if.sv
// Golden-nonce output stream of hashcore_seq: FIFO head plus valid/ready handshake.
// master: the sequencer that presents golden nonces; slave: the consumer.
interface hashcore_seq_if;
    logic [31:0] gn_data;
    logic        gn_valid;
    logic        gn_ready;

    modport master (output gn_data, output gn_valid, input gn_ready);
    modport slave  (input gn_data, input gn_valid, output gn_ready);
endinterface

// File: rtl/hashcore_seq.sv
// hashcore_seq: nonce sequencer and golden-nonce collector for one BLAKE pipeline.
// Issues {prefix, counter} nonces to a fixed-latency pipeline, maps each pipeline
// match back to the nonce issued PIPE_LATENCY cycles earlier, and queues golden
// nonces in a first-word-fallthrough FIFO with sticky overflow reporting.
// Optional macro HASHCORE_LEGACY_STROBE_EN adds golden_nonce_out/golden_nonce_match.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | after reset, counter holds, waiting for a work load
// ST_LOAD  | work shift in progress, counter holds, matches ignored
// ST_FILL  | counting, pipeline still holds results from before this load
// ST_RUN   | counting, matches belong to this load and are captured
// ST_DRAIN | last nonce issued, collecting the remaining in-flight results
// ST_DONE  | range exhausted and collected, counter holds
module hashcore_seq #(
    parameter int PREFIX_BITS  = 2,
    parameter int PIPE_LATENCY = 65,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                                          hash_clk,
    input  logic                                          reset,
    input  logic                                          shift,
    input  logic [31:0]                                   initnonce,
    input  logic [(PREFIX_BITS > 0 ? PREFIX_BITS : 1)-1:0] nonce_prefix,
    output logic [31:0]                                   nonce,
    input  logic                                          gn_match,
    hashcore_seq_if.master                                gn,
    output logic                                          gn_overflow,
    output logic                                          range_done,
    output logic                                          busy
`ifdef HASHCORE_LEGACY_STROBE_EN
    ,
    output logic [31:0]                                   golden_nonce_out,
    output logic                                          golden_nonce_match
`endif
);

    localparam int              CW       = 32 - PREFIX_BITS;
    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam logic [7:0]      LAT_LAST = 8'(PIPE_LATENCY - 1);
    localparam logic [CW-1:0]   CNT_LAST = '1;
    localparam logic [CW-1:0]   LAT_CW   = CW'(PIPE_LATENCY);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FILL,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_minus_lat;
    logic [7:0]     lat_cnt;
    logic [7:0]     drain_cnt;
    logic           exhausted;
    logic           shift_d;
    logic           shift_fall;
    logic           last_issue;
    logic           capture;
    logic [31:0]    golden;

    logic [31:0]    fifo_mem [FIFO_DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           fifo_empty;
    logic           fifo_full;
    logic           pop;
    logic           push_ok;
    logic           drop;

    // Upper initnonce bits are replaced by the core prefix and are not used.
    logic           unused_inputs;
    assign unused_inputs = ^{initnonce, nonce_prefix};

    assign shift_fall    = shift_d & ~shift;
    // Only the first pass through all-ones counts; later wraps are beyond the range.
    assign last_issue    = (cnt == CNT_LAST) && !exhausted &&
                           (state == ST_FILL || state == ST_RUN);
    assign capture       = gn_match && (state == ST_RUN || state == ST_DRAIN);
    assign cnt_minus_lat = cnt - LAT_CW;

    generate
        if (PREFIX_BITS == 0) begin : g_noprefix
            assign nonce  = cnt;
            assign golden = cnt_minus_lat;
        end else begin : g_prefix
            assign nonce  = {nonce_prefix, cnt};
            assign golden = {nonce_prefix, cnt_minus_lat};
        end
    endgenerate

    assign busy       = (state == ST_FILL) || (state == ST_RUN) || (state == ST_DRAIN);
    assign range_done = (state == ST_DONE);

    // State register.
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode; a shift always restarts the load, abandoning in-flight work.
    // Exhaustion inside FILL skips RUN since the drain window is already running.
    always_comb begin
        state_nxt = state;
        if (shift) begin
            state_nxt = ST_LOAD;
        end else begin
            case (state)
                ST_IDLE:  state_nxt = ST_IDLE;
                ST_LOAD:  if (shift_d) state_nxt = ST_FILL;
                ST_FILL:  if (lat_cnt == LAT_LAST)
                              state_nxt = (exhausted || last_issue) ? ST_DRAIN : ST_RUN;
                ST_RUN:   if (last_issue) state_nxt = ST_DRAIN;
                ST_DRAIN: if (drain_cnt == LAT_LAST) state_nxt = ST_DONE;
                default:  state_nxt = state;
            endcase
        end
    end

    // Nonce counter, fill counter and drain counter (drain counts from the last issue).
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            lat_cnt   <= '0;
            drain_cnt <= '0;
            exhausted <= 1'b0;
            shift_d   <= 1'b0;
        end else begin
            shift_d <= shift;
            case (state)
                ST_LOAD: begin
                    if (shift_fall) begin
                        cnt       <= initnonce[CW-1:0];
                        lat_cnt   <= '0;
                        drain_cnt <= '0;
                        exhausted <= 1'b0;
                    end
                end
                ST_FILL: begin
                    cnt     <= cnt + CW'(1);
                    lat_cnt <= lat_cnt + 8'd1;
                end
                ST_RUN, ST_DRAIN: cnt <= cnt + CW'(1);
                default: cnt <= cnt;
            endcase
            if (last_issue) begin
                exhausted <= 1'b1;
                drain_cnt <= '0;
            end else if (exhausted && (state == ST_FILL || state == ST_DRAIN)) begin
                drain_cnt <= drain_cnt + 8'd1;
            end
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = gn.gn_valid & gn.gn_ready;
    // A pop in the same cycle frees the slot, so a full FIFO only drops without one.
    assign push_ok    = capture && (!fifo_full || pop);
    assign drop       = capture && fifo_full && !pop;

    assign gn.gn_valid = !fifo_empty;
    assign gn.gn_data  = fifo_mem[rd_ptr[AW-1:0]];

    // FIFO storage, no reset needed since reads are qualified by gn_valid.
    always_ff @(posedge hash_clk) begin
        if (push_ok) fifo_mem[wr_ptr[AW-1:0]] <= golden;
    end

    // FIFO pointers.
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Sticky overflow, cleared when a new load completes.
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset)                               gn_overflow <= 1'b0;
        else if (state == ST_LOAD && shift_fall) gn_overflow <= 1'b0;
        else if (drop)                           gn_overflow <= 1'b1;
    end

`ifdef HASHCORE_LEGACY_STROBE_EN
    // Last captured golden nonce and capture strobe for the serial link, FIFO drops included.
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            golden_nonce_out   <= '0;
            golden_nonce_match <= 1'b0;
        end else begin
            golden_nonce_match <= capture;
            if (capture) golden_nonce_out <= golden;
        end
    end
`else
    // Default build carries no serial-link strobe logic.
`endif

endmodule

// File: tb/tb_hashcore_seq.sv
`timescale 1ns/1ps
module tb_hashcore_seq;
    localparam int PREFIX_BITS = 2;
    localparam int LAT         = 65;
    localparam int DEPTH       = 4;
    localparam int CW          = 32 - PREFIX_BITS;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic        hash_clk = 1'b0;
    logic        reset = 1'b1;
    logic        shift = 1'b0;
    logic        gn_match = 1'b0;
    logic [31:0] initnonce = '0;
    logic [1:0]  nonce_prefix = 2'b01;
    logic [31:0] nonce;
    logic        gn_overflow, range_done, busy;
`ifdef HASHCORE_LEGACY_STROBE_EN
    logic [31:0] golden_nonce_out;
    logic        golden_nonce_match;
`endif

    hashcore_seq_if gn_bus();

    always #5 hash_clk = ~hash_clk;

    hashcore_seq #(.PREFIX_BITS(PREFIX_BITS), .PIPE_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .hash_clk    (hash_clk),
        .reset       (reset),
        .shift       (shift),
        .initnonce   (initnonce),
        .nonce_prefix(nonce_prefix),
        .nonce       (nonce),
        .gn_match    (gn_match),
        .gn          (gn_bus),
        .gn_overflow (gn_overflow),
        .range_done  (range_done),
        .busy        (busy)
`ifdef HASHCORE_LEGACY_STROBE_EN
        ,
        .golden_nonce_out  (golden_nonce_out),
        .golden_nonce_match(golden_nonce_match)
`endif
    );

    // Reference model: a load issues init, init+1, ... starting at cycle f_cyc; the
    // nonce with index k is in range while k <= span, and its match arrives LAT cycles later.
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    bit            m_active = 0;
    longint        f_cyc = 0;
    logic [CW-1:0] m_init = '0;
    longint        m_span = 0;
    int            m_cnt = 0;
    bit            m_ovf = 0;
    bit            prev_shift = 0;
    logic [31:0]   m_last = '0;
    bit            m_strobe = 0;
    logic [31:0]   exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // One clock: check outputs left by the last edge, drive inputs, advance the model.
    task automatic tick(input bit s, input bit m, input bit r);
        longint      k;
        longint      t_end;
        bit          cap;
        bit          pop;
        logic [31:0] g;
        @(posedge hash_clk);
        #1;
        cyc++;
        chk("gn_valid", gn_bus.gn_valid, m_cnt > 0);
        chk("gn_overflow", gn_overflow, m_ovf);
`ifdef HASHCORE_LEGACY_STROBE_EN
        chk("golden_nonce_out", golden_nonce_out, m_last);
        chk("golden_nonce_match", golden_nonce_match, m_strobe);
`endif
        if (m_active && cyc >= f_cyc) begin
            t_end = f_cyc + m_span + LAT;
            chk("busy", busy, cyc <= t_end);
            chk("range_done", range_done, cyc > t_end);
            k = (cyc <= t_end) ? cyc - f_cyc : m_span + LAT + 1;
            chk("nonce", nonce, {nonce_prefix, m_init + CW'(k)});
        end
        shift = s;
        gn_match = m;
        gn_bus.gn_ready = r;
        pop = (m_cnt > 0) && r;
        cap = 0;
        k = 0;
        if (m_active && m) begin
            k = cyc - f_cyc - LAT;
            if (k >= 0 && k <= m_span) cap = 1;
        end
        m_strobe = cap;
        if (cap) begin
            g = {nonce_prefix, m_init + CW'(k)};
            m_last = g;
            if (m_cnt < DEPTH || pop) begin
                exp_q.push_back(g);
                m_cnt++;
            end else begin
                m_ovf = 1;
            end
        end
        if (pop) m_cnt--;
        if (s) begin
            m_active = 0;
        end else if (prev_shift) begin
            m_active = 1;
            f_cyc = cyc + 1;
            m_init = initnonce[CW-1:0];
            m_span = longint'(CNT_MAX - m_init);
            m_ovf = 0;
        end
        prev_shift = s;
    endtask

    task automatic load(input logic [31:0] init, input logic [1:0] pfx);
        tick(1, 0, 0);
        initnonce = init;
        nonce_prefix = pfx;
        tick(1, 0, 0);
        tick(1, 0, 0);
        tick(0, 0, 0);
    endtask

    task automatic idle_to(input longint target, input bit r);
        while (longint'(cyc) + 1 < target) tick(0, 0, r);
    endtask

    task automatic do_reset();
        @(posedge hash_clk);
        #2;
        reset = 1;
        shift = 0;
        gn_match = 0;
        gn_bus.gn_ready = 0;
        #1;
        chk("rst_nonce", nonce, {nonce_prefix, 30'h0});
        chk("rst_gn_valid", gn_bus.gn_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_range_done", range_done, 0);
        chk("rst_overflow", gn_overflow, 0);
        exp_q.delete();
        m_cnt = 0;
        m_ovf = 0;
        m_active = 0;
        prev_shift = 0;
        m_last = '0;
        m_strobe = 0;
        @(posedge hash_clk);
        #1;
        reset = 0;
    endtask

    // Scoreboard monitor: every accepted FIFO word must be the oldest expected one.
    always @(negedge hash_clk) begin
        if (!reset && gn_bus.gn_valid && gn_bus.gn_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL fifo_pop: got 0x%08h expected no entry", gn_bus.gn_data);
            end else begin
                chk("gn_data", gn_bus.gn_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] init32;
        int          len;
        gn_bus.gn_ready = 0;
        do_reset();

        // Capture mapping and FILL masking.
        load(32'h0000_0100, 2'b01);
        idle_to(f_cyc + 30, 0);
        tick(0, 1, 0);
        idle_to(f_cyc + 70, 0);
        tick(0, 1, 0);
        tick(0, 0, 0);
        chk("dir_gn_data", gn_bus.gn_data, 32'h4000_0105);
        chk("dir_gn_valid", gn_bus.gn_valid, 1);
        tick(0, 0, 1);
        tick(0, 0, 0);

        // Overflow: five matches into a stalled FIFO, then a sixth while popping.
        repeat (5) tick(0, 1, 0);
        tick(0, 0, 0);
        chk("ovf_set", gn_overflow, 1);
        tick(0, 1, 1);
        repeat (6) tick(0, 0, 1);
        tick(0, 0, 0);

        // Reset in RUN with counter at 0x1234.
        load(32'h0000_11EE, 2'b01);
        idle_to(f_cyc + 70, 0);
        do_reset();
        tick(0, 0, 0);

        // Range exhaustion.
        load(32'h3FFF_FFF0, 2'b00);
        idle_to(f_cyc + 80, 0);
        tick(0, 1, 0);
        tick(0, 0, 0);
        chk("exh_gn_data", gn_bus.gn_data, 32'h3FFF_FFFF);
        chk("exh_range_done", range_done, 1);
        repeat (3) tick(0, 1, 0);
        tick(0, 0, 1);
        tick(0, 0, 0);

        // Reload from DONE, then reload again during DRAIN with two entries queued.
        load(32'h3FFF_FFE0, 2'b10);
        chk("reload_range_done", range_done, 0);
        idle_to(f_cyc + 65, 0);
        repeat (5) tick(0, 1, 0);
        tick(0, 0, 1);
        tick(0, 0, 1);
        idle_to(f_cyc + 80, 0);
        chk("drain_busy", busy, 1);
        load(32'h0000_0200, 2'b11);
        tick(0, 0, 0);
        chk("reload_overflow", gn_overflow, 0);
        chk("reload_nonce", nonce, 32'hC000_0200);
        chk("reload_kept", gn_bus.gn_valid, 1);
        repeat (4) tick(0, 0, 1);

        // Randomized loads near the top of the range, some abandoned early.
        for (int it = 0; it < 8; it++) begin
            init32 = $urandom;
            init32[29:0] = CNT_MAX - 30'($urandom_range(0, 120));
            load(init32, 2'($urandom_range(0, 3)));
            len = $urandom_range(40, 220);
            for (int c = 0; c < len; c++)
                tick(0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
        end
        repeat (8) tick(0, 0, 1);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/hashcore_seq.md
Name: hashcore_seq

Overview:
- Parametrised nonce sequencer and golden-nonce collector for one BLAKE pipeline instance in a multicore build.
- Issues nonces to an external fixed-latency hash pipeline.
- Back-annotates pipeline match strobes to the nonce that produced them.
- Queues golden nonces in a FIFO with valid/ready handshake, adds range-exhaustion detection, and provides sticky overflow reporting.

Parameters:
PREFIX_BITS, 2, hardwired nonce MSBs per core (0..8); counter width CW = 32-PREFIX_BITS
PIPE_LATENCY, 65, cycles from nonce issue to gn_match for that nonce (2..255)
FIFO_DEPTH, 4, golden-nonce FIFO entries; power of two, 2..16

Ports:
hash_clk  in  1  sole clock
reset  in  1  asynchronous, active-high reset
shift  in  1  work-load shift in progress (high for whole load)
initnonce  in  32  start nonce from loaded work; bits [CW-1:0] used
nonce_prefix  in  PREFIX_BITS  core ID, becomes nonce[31:CW]
nonce  out  32  nonce presented to pipeline this cycle
gn_match  in  1  pipeline match for nonce issued PIPE_LATENCY cycles ago
gn_data  out  32  FIFO head golden nonce
gn_valid  out  1  FIFO not empty
gn_ready  in  1  consumer accepts head when gn_valid & gn_ready
gn_overflow  out  1  sticky: a match was dropped since last load
range_done  out  1  counter range exhausted, all in-flight results collected
busy  out  1  state is FILL, RUN or DRAIN

Behaviour:
- Reset (async assert, sync-release usage assumed by system): state IDLE, counter 0, fill/drain counter 0, FIFO empty, all outputs 0 except nonce = {nonce_prefix, CW'b0}.
- nonce = {nonce_prefix, cnt}, combinational from registered cnt.
- States:
  - IDLE: counter holds. shift=1 -> LOAD.
  - LOAD: counter holds; gn_match ignored. On shift falling edge (shift_d & ~shift): cnt <= initnonce[CW-1:0], lat_cnt <= 0, gn_overflow <= 0, range_done <= 0 -> FILL.
  - FILL: cnt++ each cycle; gn_match ignored while lat_cnt < PIPE_LATENCY; lat_cnt++. At lat_cnt == PIPE_LATENCY-1 -> RUN.
  - RUN: cnt++; gn_match captured. When cnt == all-ones (last nonce issued) -> DRAIN, lat_cnt <= 0.
  - DRAIN: cnt keeps incrementing (wraps; results discarded by range); gn_match captured for exactly PIPE_LATENCY cycles after last-nonce issue -> DONE.
  - DONE: range_done = 1, counter holds, gn_match ignored.
  - shift=1 in any state -> LOAD (abandons in-flight work; FIFO contents retained).
- Capture: golden = {nonce_prefix, (cnt - PIPE_LATENCY) mod 2^CW}, computed at the gn_match cycle; wrap of the subtraction is modular.
- FIFO: first-word-fallthrough; gn_data valid whenever gn_valid.
  - Push when captured match. Pop on gn_valid & gn_ready.
  - Full with push and no pop: drop the new entry, set gn_overflow.
  - Full with push and pop in same cycle: both occur, no drop.
  - Empty with push: gn_valid rises next cycle.
- range_done clears on entry to LOAD.

Optional Feature:
- Macro HASHCORE_LEGACY_STROBE_EN.
- Defined: adds outputs golden_nonce_out[31:0] (register, last captured golden nonce, reset 0, updated even if FIFO drops) and golden_nonce_match (1-cycle strobe per capture, reset 0) for serial-comms back-compat.
- Undefined: ports absent, no extra logic.

Test Plan:
- Reset mid-RUN (cnt=0x1234) -> next edge-free sample: nonce={prefix,0}, gn_valid=0, busy=0, state IDLE.
- prefix=2'b01, load initnonce=0x00000100, gn_match pulse 70 cycles after shift fall -> one FIFO entry gn_data=0x40000105, gn_valid=1.
- gn_match high during FILL (cycle 30 after load) -> no push, gn_overflow=0.
- FIFO_DEPTH=4, gn_ready=0, 5 matches -> 4 entries held, gn_overflow=1; 6th match with gn_ready=1 while full -> accepted, count stays 4.
- initnonce=0x3FFFFFF0 (PREFIX_BITS=2) -> RUN->DRAIN after last nonce; match 65 cycles after last issue captures 0x3FFFFFFF; range_done=1 next cycle, later gn_match ignored.
- Reload via shift while DRAIN with 2 FIFO entries -> entries preserved, gn_overflow and range_done cleared, counter reloads.
